// File: rtl/conv_seq_ctrl.sv
// Sequencer for a single-MAC 1-D convolution: walks X/F memory addresses and steers the accumulator.
// Optional build macro CONV_SEQ_CTRL_STALL_CNT_EN adds a saturating output-stall counter port.
module conv_seq_ctrl #(
    parameter  int X_SIZE  = 8,
    parameter  int F_SIZE  = 4,
    parameter  int STRIDE  = 1,
    localparam int XA_W    = (X_SIZE > 1) ? $clog2(X_SIZE) : 1,
    localparam int FA_W    = (F_SIZE > 1) ? $clog2(F_SIZE) : 1,
    localparam int NUM_OUT = (X_SIZE - F_SIZE) / STRIDE + 1,
    localparam int OI_W    = $clog2(NUM_OUT + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            m_ready_y,
    output logic            rd_en,
    output logic [XA_W-1:0] x_rd_addr,
    output logic [FA_W-1:0] f_rd_addr,
    output logic            acc_clr,
    output logic            acc_en,
    output logic            m_valid_y,
    output logic [OI_W-1:0] out_idx,
    output logic            busy,
    output logic            conv_done
`ifdef CONV_SEQ_CTRL_STALL_CNT_EN
    ,
    output logic [15:0]     stall_cnt
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        MAC,
        DRAIN,
        OUT
    } state_t;

    state_t          state;
    logic [FA_W-1:0] k;
    logic [XA_W-1:0] base;

    // CLEAR already issues tap 0 alongside acc_clr, so MAC covers taps 1..F_SIZE-1
    // and one output costs F_SIZE+2 cycles (CLEAR, F_SIZE-1 x MAC, DRAIN, OUT).
    // NOTE: every register here uses <= so all updates see the pre-edge values of each other.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            k         <= '0;
            base      <= '0;
            out_idx   <= '0;
            rd_en     <= 1'b0;
            x_rd_addr <= '0;
            f_rd_addr <= '0;
            acc_clr   <= 1'b0;
            acc_en    <= 1'b0;
            m_valid_y <= 1'b0;
            busy      <= 1'b0;
            conv_done <= 1'b0;
`ifdef CONV_SEQ_CTRL_STALL_CNT_EN
            stall_cnt <= '0;
`endif
        end else begin
            // Read data lands one cycle after the strobe, so accumulate one cycle late.
            acc_en    <= rd_en;
            conv_done <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= CLEAR;
                        k         <= '0;
                        base      <= '0;
                        out_idx   <= '0;
                        acc_clr   <= 1'b1;
                        rd_en     <= 1'b1;
                        x_rd_addr <= '0;
                        f_rd_addr <= '0;
                        busy      <= 1'b1;
`ifdef CONV_SEQ_CTRL_STALL_CNT_EN
                        stall_cnt <= '0;
`endif
                    end
                end

                CLEAR, MAC: begin
                    acc_clr <= 1'b0;
                    if (k == FA_W'(F_SIZE - 1)) begin
                        state <= DRAIN;
                        rd_en <= 1'b0;
                    end else begin
                        state     <= MAC;
                        k         <= k + FA_W'(1);
                        rd_en     <= 1'b1;
                        x_rd_addr <= base + XA_W'(k) + XA_W'(1);
                        f_rd_addr <= k + FA_W'(1);
                    end
                end

                DRAIN: begin
                    state     <= OUT;
                    m_valid_y <= 1'b1;
                end

                OUT: begin
                    if (m_ready_y) begin
                        m_valid_y <= 1'b0;
                        if (out_idx == OI_W'(NUM_OUT - 1)) begin
                            state     <= IDLE;
                            busy      <= 1'b0;
                            conv_done <= 1'b1;
                        end else begin
                            state     <= CLEAR;
                            k         <= '0;
                            base      <= base + XA_W'(STRIDE);
                            out_idx   <= out_idx + OI_W'(1);
                            acc_clr   <= 1'b1;
                            rd_en     <= 1'b1;
                            x_rd_addr <= base + XA_W'(STRIDE);
                            f_rd_addr <= '0;
                        end
                    end
`ifdef CONV_SEQ_CTRL_STALL_CNT_EN
                    else if (stall_cnt != 16'hFFFF) begin
                        stall_cnt <= stall_cnt + 16'd1;
                    end
`endif
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
